// File: rtl/tdma_txq_dispatch.sv
// tdma_txq_dispatch: round-robin multi-queue TX descriptor dispatcher writing ath9k TXDP over IPIC-lite.
// Optional TDMA_SLOT_GATE_EN adds slot_open gating and a slot_miss_cnt counter.
module tdma_txq_dispatch #(
  parameter int NUM_CH = 2,
  parameter int CH_W = 3,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] ATH9K_BASE = 32'h6000_0000,
  parameter logic [ADDR_WIDTH-1:0] TXDP_BASE = 32'h0000_0800,
  parameter logic [4*NUM_CH-1:0] QNUM_MAP = {4'd1, 4'd6}
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              send_req,
  input  logic [NUM_CH-1:0]              ovf_clr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   desc_dread,
  input  logic [NUM_CH-1:0]              desc_valid,
  output logic [NUM_CH-1:0]              desc_rd_en,
  output logic                           recycle_wr_start,
  output logic [DATA_WIDTH-1:0]          recycle_wr_data,
  output logic [CH_W-1:0]                recycle_ch,
  input  logic                           recycle_wr_done,
  input  logic                           irq_busy,
  input  logic [3:0]                     curr_ipic_lite_state,
  output logic [2:0]                     ipic_type_lite,
  output logic                           ipic_start_lite,
  input  logic                           ipic_ack_lite,
  input  logic                           ipic_done_lite_wire,
  output logic [ADDR_WIDTH-1:0]          write_addr_lite,
  output logic [DATA_WIDTH-1:0]          write_data_lite,
  output logic [NUM_CH*CNT_WIDTH-1:0]    pending_cnt,
  output logic [NUM_CH-1:0]              ovf_flag,
`ifdef TDMA_SLOT_GATE_EN
  input  logic                           slot_open,
  output logic [15:0]                    slot_miss_cnt,
`endif
  output logic                           busy
);
  typedef enum logic [1:0] {IDLE, POP, ACK, DONE} state_t;
  state_t state, next;
  logic [NUM_CH-1:0] req_q, rise, eligible, gnt_vec;
  logic [CNT_WIDTH-1:0] cnt [NUM_CH];
  logic [CH_W-1:0] last_grant, gnt;
  logic [DATA_WIDTH-1:0] head;
  logic [3:0] qnum;
  logic found, grant, both, gate, seen_lite, seen_rc;
`ifdef TDMA_SLOT_GATE_EN
  assign gate = slot_open;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) slot_miss_cnt <= '0;
    else if ((|pending_cnt) && !slot_open) slot_miss_cnt <= slot_miss_cnt + 16'd1;
`else
  assign gate = 1'b1;
`endif
  assign rise = send_req & ~req_q;
  assign grant = (state == IDLE) & found;
  assign gnt_vec = grant ? NUM_CH'(1) << gnt : '0;
  assign both = (seen_lite | ipic_done_lite_wire) & (seen_rc | recycle_wr_done);
  assign busy = state != IDLE;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign cnt[c] = pending_cnt[c*CNT_WIDTH +: CNT_WIDTH];
    assign eligible[c] = (cnt[c] != '0) & desc_valid[c] & ~irq_busy & gate;
  end
  // Offset-major search so the channel after last_grant wins ties
  always_comb begin
    found = 1'b0;
    gnt = '0;
    for (int i = 1; i <= NUM_CH; i++)
      for (int c = 0; c < NUM_CH; c++)
        if (!found && eligible[c] && CH_W'((int'(last_grant) + i) % NUM_CH) == CH_W'(c)) begin
          found = 1'b1;
          gnt = CH_W'(c);
        end
  end
  always_comb begin
    head = '0;
    qnum = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (gnt == CH_W'(c)) begin
        head = desc_dread[c*DATA_WIDTH +: DATA_WIDTH];
        qnum = QNUM_MAP[c*4 +: 4];
      end
  end
  always_comb begin
    next = state;
    case (state)
      IDLE: next = found ? POP : IDLE;
      POP:  next = (curr_ipic_lite_state == 4'd0) ? ACK : POP;
      ACK:  next = ipic_ack_lite ? DONE : ACK;
      DONE: next = both ? IDLE : DONE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      req_q <= '0;
      pending_cnt <= '0;
      ovf_flag <= '0;
    end else begin
      req_q <= send_req;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rise[c] && !gnt_vec[c])
          pending_cnt[c*CNT_WIDTH +: CNT_WIDTH] <= (&cnt[c]) ? cnt[c] : cnt[c] + 1'b1;
        else if (gnt_vec[c] && !rise[c])
          pending_cnt[c*CNT_WIDTH +: CNT_WIDTH] <= cnt[c] - 1'b1;
        ovf_flag[c] <= (rise[c] & ~gnt_vec[c] & (&cnt[c])) | (ovf_flag[c] & ~ovf_clr[c]);
      end
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      last_grant <= CH_W'(NUM_CH - 1);
      desc_rd_en <= '0;
      write_data_lite <= '0;
      recycle_wr_data <= '0;
      write_addr_lite <= '0;
      recycle_ch <= '0;
      ipic_type_lite <= '0;
      ipic_start_lite <= 1'b0;
      recycle_wr_start <= 1'b0;
      seen_lite <= 1'b0;
      seen_rc <= 1'b0;
    end else begin
      desc_rd_en <= gnt_vec;
      if (grant) begin
        last_grant <= gnt;
        write_data_lite <= head;
        recycle_wr_data <= head;
        write_addr_lite <= ATH9K_BASE + TXDP_BASE + ADDR_WIDTH'({qnum, 2'b00});
        recycle_ch <= gnt;
        ipic_type_lite <= 3'd3;
      end
      if (state == POP && next == ACK) begin
        ipic_start_lite <= 1'b1;
        recycle_wr_start <= 1'b1;
      end else if (state == ACK && ipic_ack_lite) begin
        ipic_start_lite <= 1'b0;
        recycle_wr_start <= 1'b0;
      end
      seen_lite <= (state == DONE) & ~both & (seen_lite | ipic_done_lite_wire);
      seen_rc <= (state == DONE) & ~both & (seen_rc | recycle_wr_done);
    end
endmodule

// File: tb/tb_tdma_txq_dispatch.sv
// tb_tdma_txq_dispatch: directed self-checking bench for tdma_txq_dispatch with default parameters.
module tb_tdma_txq_dispatch;
  logic clk, reset_n;
  logic [1:0] send_req, ovf_clr, desc_valid, desc_rd_en, ovf_flag;
  logic [63:0] desc_dread;
  logic recycle_wr_start, recycle_wr_done, irq_busy;
  logic [31:0] recycle_wr_data, write_addr_lite, write_data_lite;
  logic [2:0] recycle_ch, ipic_type_lite;
  logic [3:0] curr_ipic_lite_state;
  logic ipic_start_lite, ipic_ack_lite, ipic_done_lite_wire, busy;
  logic [9:0] pending_cnt;
`ifdef TDMA_SLOT_GATE_EN
  logic [15:0] slot_miss_cnt;
`endif
  int checks = 0;
  int errors = 0;

  tdma_txq_dispatch dut (
    .clk(clk), .reset_n(reset_n), .send_req(send_req), .ovf_clr(ovf_clr),
    .desc_dread(desc_dread), .desc_valid(desc_valid), .desc_rd_en(desc_rd_en),
    .recycle_wr_start(recycle_wr_start), .recycle_wr_data(recycle_wr_data),
    .recycle_ch(recycle_ch), .recycle_wr_done(recycle_wr_done), .irq_busy(irq_busy),
    .curr_ipic_lite_state(curr_ipic_lite_state), .ipic_type_lite(ipic_type_lite),
    .ipic_start_lite(ipic_start_lite), .ipic_ack_lite(ipic_ack_lite),
    .ipic_done_lite_wire(ipic_done_lite_wire), .write_addr_lite(write_addr_lite),
    .write_data_lite(write_data_lite), .pending_cnt(pending_cnt), .ovf_flag(ovf_flag),
`ifdef TDMA_SLOT_GATE_EN
    .slot_open(1'b1), .slot_miss_cnt(slot_miss_cnt),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    send_req = '0;
    ovf_clr = '0;
    irq_busy = 1'b0;
    ipic_ack_lite = 1'b0;
    ipic_done_lite_wire = 1'b0;
    recycle_wr_done = 1'b0;
    curr_ipic_lite_state = '0;
    desc_valid = 2'b11;
    desc_dread = {32'h2000_0080, 32'h1000_0040};
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic pulse(input logic [1:0] m);
    send_req = m;
    tick();
    send_req = '0;
    tick();
  endtask

  // Bounded wait for a grant, then walk the FSM through POP and ACK into DONE
  task automatic to_done(output int ch, output logic [31:0] addr, output logic [31:0] data);
    int n = 0;
    while (desc_rd_en == 2'b00 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (desc_rd_en == 2'b00) begin
      errors++;
      $display("FAIL grant_timeout: desc_rd_en=%b after %0d cycles", desc_rd_en, n);
    end
    ch = desc_rd_en == 2'b01 ? 0 : desc_rd_en == 2'b10 ? 1 : -1;
    addr = write_addr_lite;
    data = write_data_lite;
    tick();
    ipic_ack_lite = 1'b1;
    tick();
    ipic_ack_lite = 1'b0;
  endtask

  task automatic serve(output int ch, output logic [31:0] addr, output logic [31:0] data);
    to_done(ch, addr, data);
    ipic_done_lite_wire = 1'b1;
    recycle_wr_done = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    recycle_wr_done = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({desc_rd_en, recycle_wr_start, recycle_wr_data, recycle_ch, ipic_type_lite, ipic_start_lite,
         write_addr_lite, write_data_lite, pending_cnt, ovf_flag, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b pend=%h addr=%h want all zero", busy, pending_cnt, write_addr_lite);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    send_req = 2'b01;
    tick();
    send_req = 2'b00;
    checks++;
    if (pending_cnt[4:0] !== 5'd1) begin errors++; $display("FAIL single_pend_inc: got %0d want 1", pending_cnt[4:0]); end
    curr_ipic_lite_state = 4'd5;
    tick();
    checks++;
    if (desc_rd_en !== 2'b01) begin errors++; $display("FAIL single_rd_en: got %b want 01", desc_rd_en); end
    checks++;
    if (write_addr_lite !== 32'h6000_0818) begin errors++; $display("FAIL single_addr: got %h want 60000818", write_addr_lite); end
    checks++;
    if (write_data_lite !== 32'h1000_0040) begin errors++; $display("FAIL single_data: got %h want 10000040", write_data_lite); end
    checks++;
    if (pending_cnt[4:0] !== 5'd0) begin errors++; $display("FAIL single_pend_dec: got %0d want 0", pending_cnt[4:0]); end
    desc_valid = 2'b10;
    tick();
    checks++;
    if ({desc_rd_en, ipic_start_lite, busy} !== 4'b0001) begin
      errors++;
      $display("FAIL single_pop_wait: rd_en=%b start=%b busy=%b want 00 0 1", desc_rd_en, ipic_start_lite, busy);
    end
    curr_ipic_lite_state = 4'd0;
    tick();
    checks++;
    if ({ipic_start_lite, recycle_wr_start, ipic_type_lite} !== 5'b11011) begin
      errors++;
      $display("FAIL single_start: start=%b rstart=%b type=%0d want 1 1 3", ipic_start_lite, recycle_wr_start, ipic_type_lite);
    end
    ipic_ack_lite = 1'b1;
    tick();
    ipic_ack_lite = 1'b0;
    checks++;
    if ({ipic_start_lite, recycle_wr_start} !== 2'b00) begin errors++; $display("FAIL single_ack_drop: got %b want 00", {ipic_start_lite, recycle_wr_start}); end
    ipic_done_lite_wire = 1'b1;
    recycle_wr_done = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    recycle_wr_done = 1'b0;
    checks++;
    if ({busy, pending_cnt[4:0], recycle_ch} !== 9'd0) begin
      errors++;
      $display("FAIL single_end: busy=%b pend=%0d ch=%0d want 0 0 0", busy, pending_cnt[4:0], recycle_ch);
    end
    checks++;
    if (recycle_wr_data !== 32'h1000_0040) begin errors++; $display("FAIL single_recycle_data: got %h want 10000040", recycle_wr_data); end
  endtask

  task automatic test_round_robin();
    int ch;
    logic [31:0] a, d;
    int exp_ch [4] = '{0, 1, 0, 1};
    logic [31:0] exp_a [2] = '{32'h6000_0818, 32'h6000_0804};
    logic [31:0] exp_d [2] = '{32'h1000_0040, 32'h2000_0080};
    do_reset();
    irq_busy = 1'b1;
    pulse(2'b11);
    pulse(2'b11);
    checks++;
    if (pending_cnt !== 10'h042) begin errors++; $display("FAIL rr_pending: got %h want 042", pending_cnt); end
    irq_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      serve(ch, a, d);
      checks++;
      if (ch !== exp_ch[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, ch, exp_ch[i]); end
      checks++;
      if (a !== exp_a[exp_ch[i]] || d !== exp_d[exp_ch[i]]) begin
        errors++;
        $display("FAIL rr_addr_data[%0d]: got %h/%h want %h/%h", i, a, d, exp_a[exp_ch[i]], exp_d[exp_ch[i]]);
      end
    end
    checks++;
    if (pending_cnt !== 10'h000) begin errors++; $display("FAIL rr_drained: got %h want 000", pending_cnt); end
  endtask

  task automatic test_overflow();
    do_reset();
    desc_valid = 2'b00;
    for (int i = 0; i < 31; i++) pulse(2'b10);
    checks++;
    if ({pending_cnt[9:5], ovf_flag} !== {5'd31, 2'b00}) begin
      errors++;
      $display("FAIL ovf_at_max: cnt=%0d flag=%b want 31 00", pending_cnt[9:5], ovf_flag);
    end
    pulse(2'b10);
    checks++;
    if ({pending_cnt[9:5], ovf_flag} !== {5'd31, 2'b10}) begin
      errors++;
      $display("FAIL ovf_saturate: cnt=%0d flag=%b want 31 10", pending_cnt[9:5], ovf_flag);
    end
    ovf_clr = 2'b10;
    tick();
    ovf_clr = 2'b00;
    checks++;
    if ({pending_cnt[9:5], ovf_flag} !== {5'd31, 2'b00}) begin
      errors++;
      $display("FAIL ovf_clear: cnt=%0d flag=%b want 31 00", pending_cnt[9:5], ovf_flag);
    end
  endtask

  task automatic test_same_cycle();
    do_reset();
    irq_busy = 1'b1;
    pulse(2'b01);
    pulse(2'b01);
    send_req = 2'b01;
    irq_busy = 1'b0;
    tick();
    send_req = 2'b00;
    checks++;
    if ({desc_rd_en, pending_cnt[4:0]} !== {2'b01, 5'd2}) begin
      errors++;
      $display("FAIL same_cycle: rd_en=%b pend=%0d want 01 2", desc_rd_en, pending_cnt[4:0]);
    end
  endtask

  task automatic test_done_order();
    int ch;
    logic [31:0] a, d;
    do_reset();
    pulse(2'b01);
    to_done(ch, a, d);
    ipic_done_lite_wire = 1'b1;
    tick();
    ipic_done_lite_wire = 1'b0;
    tick();
    tick();
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_wait_rc: busy=%b want 1", busy); end
    recycle_wr_done = 1'b1;
    tick();
    recycle_wr_done = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL done_after_rc: busy=%b want 0", busy); end
    pulse(2'b10);
    serve(ch, a, d);
    checks++;
    if ({busy, ch[1:0]} !== 3'b001) begin errors++; $display("FAIL done_same_cycle: busy=%b ch=%0d want 0 1", busy, ch); end
    tick();
    checks++;
    if ({busy, desc_rd_en} !== 3'b000) begin errors++; $display("FAIL done_single_return: busy=%b rd_en=%b want 0 00", busy, desc_rd_en); end
  endtask

  task automatic test_irq_busy_reset();
    logic [1:0] seen = '0;
    do_reset();
    irq_busy = 1'b1;
    pulse(2'b01);
    for (int i = 0; i < 5; i++) begin
      seen |= desc_rd_en;
      tick();
    end
    checks++;
    if ({seen, busy, pending_cnt[4:0]} !== {2'b00, 1'b0, 5'd1}) begin
      errors++;
      $display("FAIL irq_block: rd_en_seen=%b busy=%b pend=%0d want 00 0 1", seen, busy, pending_cnt[4:0]);
    end
    irq_busy = 1'b0;
    tick();
    checks++;
    if (desc_rd_en !== 2'b01) begin errors++; $display("FAIL irq_release_grant: got %b want 01", desc_rd_en); end
    tick();
    checks++;
    if ({ipic_start_lite, busy} !== 2'b11) begin errors++; $display("FAIL in_ack: start=%b busy=%b want 1 1", ipic_start_lite, busy); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({desc_rd_en, recycle_wr_start, recycle_wr_data, recycle_ch, ipic_type_lite, ipic_start_lite,
         write_addr_lite, write_data_lite, pending_cnt, ovf_flag, busy} !== '0) begin
      errors++;
      $display("FAIL async_reset: start=%b busy=%b addr=%h want all zero", ipic_start_lite, busy, write_addr_lite);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if ({busy, desc_rd_en} !== 3'b000) begin errors++; $display("FAIL post_reset_idle: busy=%b rd_en=%b want 0 00", busy, desc_rd_en); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_overflow();
    test_same_cycle();
    test_done_order();
    test_irq_busy_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
